// File: rtl/noc_sync_pkg.sv
// noc_sync_pkg
//   Shared definitions for the synchronous SDM NoC router blocks:
//   flit-type bit positions, output-port direction indices, the per-VC
//   input-buffer state encoding, head-flit address field offsets, and the
//   XY routing function.
package noc_sync_pkg;

    // flit type is one-hot; HOF|EOF marks a single-flit packet
    localparam int FT_HOF = 0;
    localparam int FT_BOF = 1;
    localparam int FT_EOF = 2;

    // output port indices inside a one-hot route vector
    localparam int DIR_S = 0;
    localparam int DIR_W = 1;
    localparam int DIR_N = 2;
    localparam int DIR_E = 3;
    localparam int DIR_L = 4;

    // destination address fields inside a head flit
    localparam int ADDR_W     = 8;
    localparam int ADDR_X_LSB = 0;
    localparam int ADDR_Y_LSB = 8;

    typedef enum logic [1:0] {
        VC_IDLE = 2'd0,
        VC_RC   = 2'd1,
        VC_VA   = 2'd2,
        VC_ACT  = 2'd3
    } vc_state_e;

    // dimension-ordered routing: resolve x first, then y, else deliver locally
    function automatic logic [4:0] route_xy(
        input logic [ADDR_W-1:0] dst_x,
        input logic [ADDR_W-1:0] dst_y,
        input logic [ADDR_W-1:0] loc_x,
        input logic [ADDR_W-1:0] loc_y
    );
        logic [4:0] r;
        r = '0;
        if (dst_x > loc_x)      r[DIR_E] = 1'b1;
        else if (dst_x < loc_x) r[DIR_W] = 1'b1;
        else if (dst_y > loc_y) r[DIR_N] = 1'b1;
        else if (dst_y < loc_y) r[DIR_S] = 1'b1;
        else                    r[DIR_L] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// vc_fifo
//   Single-VC flit FIFO: register array, wrapping read/write pointers and
//   an occupancy count. DEPTH must be a power of two so the pointers wrap
//   by plain overflow.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (empties the FIFO)
//   push, wdata   write request and entry
//   pop           read request; takes the current front entry
//   rdata         front entry, zero while empty
//   full, empty   occupancy flags
//   A push while full is accepted only together with a pop.
module vc_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH[AW:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // gating keeps the outputs at zero after reset and between packets
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/vc_inpbuf_sync.sv
// vc_inpbuf_sync
//   Router input-port buffer: per-VC flit FIFOs, XY route computation on
//   head flits, VC/switch allocation handshakes and credit return.
//   Optional sticky protocol-error detection is built when the macro
//   VC_INPBUF_ERRCHK_EN is defined (adds the err port).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   div, di, dit, divc incoming flit valid, data, type, one-hot target VC
//   cor                per-VC credit pulse, one cycle after each pop
//   dout, dot          front flit data/type per VC (the flit data output;
//                      "do" is a reserved word), valid while swr is high
//   dortg              latched route of the current packet per VC
//   vcr, vcra          VC allocation request (one-hot direction) / grant
//   swr, swa           switch request / grant (grant pops the front flit)
//   addrx, addry       local router address
//   err                sticky per-VC protocol error (VC_INPBUF_ERRCHK_EN)
//
// Per-VC FSM
//   state   | meaning
//   IDLE    | waiting for a head flit at (or arriving into) the FIFO front
//   RC      | route computed from the front head flit, latched into dortg
//   VA      | requesting an output VC with vcr until vcra
//   ACT     | requesting the switch while flits are buffered, until EOF pops
module vc_inpbuf_sync
    import noc_sync_pkg::*;
#(
    parameter int DW    = 32,
    parameter int VCN   = 2,
    parameter int DEPTH = 4,
    parameter int DIR   = 0,
    parameter int SN    = 5,
    parameter int FT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div,
    input  logic [DW-1:0]     di,
    input  logic [FT-1:0]     dit,
    input  logic [VCN-1:0]    divc,
    output logic [VCN-1:0]    cor,
    output logic [VCN*DW-1:0] dout,
    output logic [VCN*FT-1:0] dot,
    output logic [VCN*SN-1:0] dortg,
    output logic [VCN*SN-1:0] vcr,
    input  logic [VCN-1:0]    vcra,
    output logic [VCN-1:0]    swr,
    input  logic [VCN-1:0]    swa,
    input  logic [7:0]        addrx,
    input  logic [7:0]        addry
`ifdef VC_INPBUF_ERRCHK_EN
    ,
    output logic [VCN-1:0]    err
`endif
);

    localparam int W = DW + FT;

    if (DIR < 0 || DIR > 4) begin : g_bad_dir
        $error("vc_inpbuf_sync: DIR must be 0..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vc_inpbuf_sync: DEPTH must be a power of two >= 2");
    end

    logic divc_ok;
    logic [VCN-1:0] push;
    logic [VCN-1:0] full;
    logic [VCN-1:0] empty;

`ifdef VC_INPBUF_ERRCHK_EN
    assign divc_ok = $onehot(divc);
`else
    assign divc_ok = 1'b1;
`endif

    assign push = (div & divc_ok) ? divc : '0;

    for (genvar v = 0; v < VCN; v++) begin : g_vc
        logic [W-1:0]  front;
        logic [DW-1:0] front_dat;
        logic [FT-1:0] front_typ;
        vc_state_e     state_q;
        vc_state_e     state_d;
        logic [SN-1:0] rtg_q;
        logic [SN-1:0] rtg_calc;
        logic          rtg_ld;
        logic          rtg_clr;
        logic          pop_v;
        logic          swr_v;
        logic [SN-1:0] vcr_v;
        logic          cor_q;

        vc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[v]),
            .pop   (pop_v),
            .wdata ({di, dit}),
            .rdata (front),
            .full  (full[v]),
            .empty (empty[v])
        );

        assign front_dat = front[W-1:FT];
        assign front_typ = front[FT-1:0];
        assign rtg_calc  = route_xy(front_dat[ADDR_X_LSB +: ADDR_W],
                                    front_dat[ADDR_Y_LSB +: ADDR_W],
                                    addrx, addry);

        always_comb begin
            state_d = state_q;
            pop_v   = 1'b0;
            swr_v   = 1'b0;
            vcr_v   = '0;
            rtg_ld  = 1'b0;
            rtg_clr = 1'b0;
            case (state_q)
                VC_IDLE: begin
                    // a head written into an empty FIFO starts RC next cycle
                    if (!empty[v]) begin
                        if (front_typ[FT_HOF]) state_d = VC_RC;
`ifdef VC_INPBUF_ERRCHK_EN
                        else pop_v = 1'b1;
`endif
                    end else if (push[v] && dit[FT_HOF]) begin
                        state_d = VC_RC;
                    end
                end
                VC_RC: begin
                    rtg_ld  = 1'b1;
                    state_d = VC_VA;
                end
                VC_VA: begin
                    vcr_v = rtg_q;
                    if (vcra[v]) state_d = VC_ACT;
                end
                VC_ACT: begin
                    swr_v = ~empty[v];
                    if (swr_v && swa[v]) begin
                        pop_v = 1'b1;
                        if (front_typ[FT_EOF]) begin
                            rtg_clr = 1'b1;
                            state_d = VC_IDLE;
                        end
                    end
                end
                default: state_d = VC_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= VC_IDLE;
                rtg_q   <= '0;
                cor_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cor_q   <= pop_v;
                if (rtg_ld)       rtg_q <= rtg_calc;
                else if (rtg_clr) rtg_q <= '0;
            end
        end

`ifdef VC_INPBUF_ERRCHK_EN
        logic err_q;
        logic err_set;
        assign err_set = (push[v] & full[v] & ~pop_v)
                       | ((state_q == VC_IDLE) & pop_v)
                       | (div & ~divc_ok);

        always_ff @(posedge clk) begin
            if (!rst_n)       err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
        end
        assign err[v] = err_q;
`endif

        assign cor[v]              = cor_q;
        assign swr[v]              = swr_v;
        assign vcr[v*SN +: SN]     = vcr_v;
        assign dortg[v*SN +: SN]   = rtg_q;
        assign dout[v*DW +: DW]    = front_dat;
        assign dot[v*FT +: FT]     = front_typ;
    end

endmodule

// File: tb/tb_vc_inpbuf_sync.sv
module tb_vc_inpbuf_sync;

    localparam int DW = 32, VCN = 2, DEPTH = 4, SN = 5, FT = 3;
    localparam logic [2:0] HOF = 3'b001, BOF = 3'b010, EOF = 3'b100, SGL = 3'b101;
    localparam logic [4:0] RS = 5'b00001, RW = 5'b00010, RN = 5'b00100,
                           RE = 5'b01000, RL = 5'b10000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              div;
    logic [DW-1:0]     di;
    logic [FT-1:0]     dit;
    logic [VCN-1:0]    divc;
    logic [VCN-1:0]    cor;
    logic [VCN*DW-1:0] dout;
    logic [VCN*FT-1:0] dot;
    logic [VCN*SN-1:0] dortg;
    logic [VCN*SN-1:0] vcr;
    logic [VCN-1:0]    vcra;
    logic [VCN-1:0]    swr;
    logic [VCN-1:0]    swa;
    logic [7:0]        addrx;
    logic [7:0]        addry;
`ifdef VC_INPBUF_ERRCHK_EN
    logic [VCN-1:0]    err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vc_inpbuf_sync #(.DW(DW), .VCN(VCN), .DEPTH(DEPTH), .DIR(0), .SN(SN), .FT(FT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (div),
        .di    (di),
        .dit   (dit),
        .divc  (divc),
        .cor   (cor),
        .dout  (dout),
        .dot   (dot),
        .dortg (dortg),
        .vcr   (vcr),
        .vcra  (vcra),
        .swr   (swr),
        .swa   (swa),
        .addrx (addrx),
        .addry (addry)
`ifdef VC_INPBUF_ERRCHK_EN
        ,
        .err   (err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hd(input logic [7:0] x, input logic [7:0] y);
        return {16'hC0DE, y, x};
    endfunction

    task automatic push(input int vc, input logic [31:0] d, input logic [2:0] t);
        div  = 1'b1;
        divc = VCN'(1) << vc;
        di   = d;
        dit  = t;
        step();
        div  = 1'b0;
        divc = '0;
    endtask

    // single-flit packet: route at t+2, grant, switch at t+3, credit at t+4
    task automatic run_single(input int vc, input logic [7:0] x, input logic [7:0] y,
                              input logic [4:0] rt, input string tag);
        push(vc, hd(x, y), SGL);
        chk({tag, "_vcr_t1"}, 64'(vcr[vc*SN +: SN]), 64'(0));
        step();
        chk({tag, "_vcr_t2"}, 64'(vcr[vc*SN +: SN]), 64'(rt));
        chk({tag, "_rtg_t2"}, 64'(dortg[vc*SN +: SN]), 64'(rt));
        vcra[vc] = 1'b1;
        step();
        vcra[vc] = 1'b0;
        chk({tag, "_swr_t3"}, 64'(swr[vc]), 64'(1));
        chk({tag, "_do_t3"}, 64'(dout[vc*DW +: DW]), 64'(hd(x, y)));
        swa[vc] = 1'b1;
        step();
        swa[vc] = 1'b0;
        chk({tag, "_cor_t4"}, 64'(cor[vc]), 64'(1));
        chk({tag, "_swr_t4"}, 64'(swr[vc]), 64'(0));
        chk({tag, "_rtg_clr"}, 64'(dortg[vc*SN +: SN]), 64'(0));
        step();
        chk({tag, "_cor_t5"}, 64'(cor[vc]), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; div = 1'b1; di = hd(3, 2); dit = SGL; divc = 2'b01;
        vcra = '0; swa = '0; addrx = 8'd2; addry = 8'd2;

        // reset with a flit presented: it must be discarded
        step();
        step();
        chk("rst_cor", 64'(cor), 64'(0));
        chk("rst_vcr", 64'(vcr), 64'(0));
        chk("rst_swr", 64'(swr), 64'(0));
        chk("rst_rtg", 64'(dortg), 64'(0));
        chk("rst_do", dout, 64'(0));
        chk("rst_dot", 64'(dot), 64'(0));
`ifdef VC_INPBUF_ERRCHK_EN
        chk("rst_err", 64'(err), 64'(0));
`endif
        rst_n = 1'b1; div = 1'b0; divc = '0;
        step();
        chk("post_rst_cor", 64'(cor), 64'(0));
        chk("post_rst_vcr", 64'(vcr), 64'(0));

        run_single(0, 8'd3, 8'd2, RE, "east");
        run_single(0, 8'd1, 8'd2, RW, "west");
        run_single(1, 8'd2, 8'd3, RN, "north");
        run_single(0, 8'd2, 8'd1, RS, "south");
        run_single(1, 8'd2, 8'd2, RL, "local");

        // back-to-back 4-flit packet filling VC1
        push(1, hd(3, 2), HOF);
        push(1, 32'h1111_0001, BOF);
        push(1, 32'h1111_0002, BOF);
        push(1, 32'h1111_0003, EOF);
        chk("b2b_vcr", 64'(vcr[9:5]), 64'(RE));
        chk("b2b_swr_va", 64'(swr[1]), 64'(0));
        vcra[1] = 1'b1;
        swa[1]  = 1'b1;   // ignored while swr is low
        step();
        vcra[1] = 1'b0;
        chk("b2b_swa_ign", 64'(cor[1]), 64'(0));
        chk("b2b_swr", 64'(swr[1]), 64'(1));
        chk("b2b_do0", 64'(dout[63:32]), 64'(hd(3, 2)));
        chk("b2b_dot0", 64'(dot[5:3]), 64'(HOF));
        step();
        chk("b2b_cor1", 64'(cor[1]), 64'(1));
        chk("b2b_do1", 64'(dout[63:32]), 64'(32'h1111_0001));
        step();
        chk("b2b_cor2", 64'(cor[1]), 64'(1));
        chk("b2b_do2", 64'(dout[63:32]), 64'(32'h1111_0002));
        step();
        chk("b2b_cor3", 64'(cor[1]), 64'(1));
        chk("b2b_dot3", 64'(dot[5:3]), 64'(EOF));
        step();
        chk("b2b_cor4", 64'(cor[1]), 64'(1));
        chk("b2b_swr_end", 64'(swr[1]), 64'(0));
        chk("b2b_rtg_clr", 64'(dortg[9:5]), 64'(0));
        swa[1] = 1'b0;
        step();
        chk("b2b_cor5", 64'(cor[1]), 64'(0));

        // interleaved packets: VC0 west 3 flits, VC1 north 2 flits
        push(0, hd(1, 2), HOF);
        push(1, hd(2, 3), HOF);
        push(0, 32'hA000_0001, BOF);
        push(1, 32'hB000_0001, EOF);
        push(0, 32'hA000_0002, EOF);
        chk("il_vcr0", 64'(vcr[4:0]), 64'(RW));
        chk("il_vcr1", 64'(vcr[9:5]), 64'(RN));
        vcra = 2'b11;
        step();
        vcra = 2'b00;
        swa  = 2'b11;
        chk("il_do0_h", 64'(dout[31:0]), 64'(hd(1, 2)));
        chk("il_do1_h", 64'(dout[63:32]), 64'(hd(2, 3)));
        step();
        chk("il_cor", 64'(cor), 64'(2'b11));
        chk("il_do0_b", 64'(dout[31:0]), 64'(32'hA000_0001));
        chk("il_do1_e", 64'(dout[63:32]), 64'(32'hB000_0001));
        step();
        chk("il_swr", 64'(swr), 64'(2'b01));
        chk("il_rtg1_clr", 64'(dortg[9:5]), 64'(0));
        chk("il_rtg0", 64'(dortg[4:0]), 64'(RW));
        chk("il_do0_e", 64'(dout[31:0]), 64'(32'hA000_0002));
        step();
        chk("il_swr_end", 64'(swr), 64'(0));
        chk("il_cor_last", 64'(cor), 64'(2'b01));
        swa = 2'b00;

        // push into full VC1 while popping: flit must be kept
        push(1, hd(2, 1), HOF);
        push(1, 32'hF000_0001, BOF);
        push(1, 32'hF000_0002, BOF);
        push(1, 32'hF000_0003, BOF);
        chk("full_vcr", 64'(vcr[9:5]), 64'(RS));
        vcra[1] = 1'b1;
        step();
        vcra[1] = 1'b0;
        swa[1]  = 1'b1;
        push(1, 32'hF000_0004, BOF);
        push(1, 32'hF000_0005, EOF);
        chk("full_do_b2", 64'(dout[63:32]), 64'(32'hF000_0002));
        step();
        step();
        chk("full_do_b4", 64'(dout[63:32]), 64'(32'hF000_0004));
        step();
        chk("full_do_e", 64'(dout[63:32]), 64'(32'hF000_0005));
        chk("full_dot_e", 64'(dot[5:3]), 64'(EOF));
        step();
        chk("full_swr_end", 64'(swr[1]), 64'(0));
        chk("full_cor_end", 64'(cor[1]), 64'(1));
        swa[1] = 1'b0;
        step();

`ifdef VC_INPBUF_ERRCHK_EN
        // body flit on idle VC0: popped silently, error flagged, credit returned
        push(0, 32'hDEAD_0001, BOF);
        step();
        chk("err_flag", 64'(err), 64'(2'b01));
        chk("err_cor", 64'(cor), 64'(2'b01));
        step();
        chk("err_cor_once", 64'(cor), 64'(0));
        chk("err_sticky", 64'(err), 64'(2'b01));
        chk("err_no_vcr", 64'(vcr), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
